panel_input_conditioner: RTL and testbench

- Front-panel input stage that sits directly upstream of the main menu/compute controller FSM.
- Synchronises and debounces the raw confirm button and the 4-bit mode switches.
- Delivers a single-cycle `btn_pulse` (drives the controller's `button`) plus a glitch-free registered `mode_sel`.
- Also reports long-press and mode-change events for the LED/segment display logic.

---
 rtl/panel_input_conditioner_pkg.sv | 35 +++
 rtl/panel_input_conditioner_if.sv | 29 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/panel_input_conditioner.sv | 190 +++++++++++++++++++
 tb/tb_panel_input_conditioner.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/panel_input_conditioner_pkg.sv
// Shared front-panel definitions.
//   - btn_state_e : confirm-button debounce FSM encoding
//   - DEF_*       : default timing constants for a 100 MHz clock
//   - MODE_*      : legal mode-switch codes, also decoded by the controller
//                   and the LED/segment display logic
//   - mode_is_legal() : 4-bit legal-code check for downstream users
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int CLK_HZ                = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES   = CLK_HZ / 50;   // 20 ms
  localparam int DEF_SW_STABLE_CYCLES  = CLK_HZ / 100;  // 10 ms
  localparam int DEF_LONG_PRESS_CYCLES = CLK_HZ;        // 1 s
  localparam int DEF_SW_W              = 4;

  localparam logic [3:0] MODE_0   = 4'b0001;
  localparam logic [3:0] MODE_1   = 4'b0010;
  localparam logic [3:0] MODE_2   = 4'b0100;
  localparam logic [3:0] MODE_3   = 4'b1000;
  localparam logic [3:0] MODE_ALL = 4'b1111;

  function automatic logic mode_is_legal(input logic [3:0] m);
    case (m)
      MODE_0, MODE_1, MODE_2, MODE_3, MODE_ALL: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/panel_input_conditioner_if.sv
// Front-panel bundle between the raw panel inputs and the conditioned
// outputs consumed by the controller and display.
//   master : drives raw button/switches, observes conditioned outputs
//   slave  : the conditioner itself
//   btn_raw, sw_raw        raw asynchronous panel inputs
//   btn_pulse/level/long   conditioned button events
//   mode_sel/valid/changed conditioned switch value and status
interface panel_input_conditioner_if #(
  parameter int SW_W = 4
);
  logic            btn_raw;
  logic [SW_W-1:0] sw_raw;
  logic            btn_pulse;
  logic            btn_level;
  logic            btn_long;
  logic [SW_W-1:0] mode_sel;
  logic            mode_valid;
  logic            mode_changed;

  modport master (
    output btn_raw, sw_raw,
    input  btn_pulse, btn_level, btn_long, mode_sel, mode_valid, mode_changed
  );

  modport slave (
    input  btn_raw, sw_raw,
    output btn_pulse, btn_level, btn_long, mode_sel, mode_valid, mode_changed
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, W bits wide.
// Each bit is synchronised independently; a multi-bit bus may be seen
// mid-transition for a cycle, which the downstream stability filter absorbs.
//   clk, rst : clock, synchronous active-high reset (clears both stages)
//   d        : asynchronous input
//   q        : synchronised output, two cycles of latency
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel input stage ahead of the menu/compute controller.
// Synchronises and debounces the confirm button and the mode switches.
//   clk, rst         : clock, synchronous active-high reset
//   pif.btn_raw      : raw confirm button
//   pif.sw_raw       : raw mode switches
//   pif.btn_pulse    : one cycle per accepted press (controller `button`)
//   pif.btn_level    : debounced button level
//   pif.btn_long     : one cycle once a press has been held long enough
//   pif.mode_sel     : debounced, registered switch value
//   pif.mode_valid   : mode_sel is one-hot or all ones
//   pif.mode_changed : one cycle on the edge mode_sel updates
module panel_input_conditioner
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int SW_STABLE_CYCLES  = DEF_SW_STABLE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int SW_W              = DEF_SW_W
) (
  input  logic                        clk,
  input  logic                        rst,
  panel_input_conditioner_if.slave    pif
);

  localparam int DC_MAX = (DEBOUNCE_CYCLES > SW_STABLE_CYCLES) ?
                          DEBOUNCE_CYCLES : SW_STABLE_CYCLES;
  localparam int DC_W   = $clog2(DC_MAX);
  localparam int SC_W   = $clog2(SW_STABLE_CYCLES);
  // hcnt needs to hold LONG_PRESS_CYCLES itself: it parks there after the
  // long-press pulse so the pulse cannot repeat within the same press.
  localparam int HC_W   = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SW_STABLE_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_SAT  = HC_W'(LONG_PRESS_CYCLES);

  // ---------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------
  logic            btn_s;
  logic [SW_W-1:0] sw_s;

  sync_2ff #(.W(1)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (pif.btn_raw),
    .q   (btn_s)
  );

  sync_2ff #(.W(SW_W)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (pif.sw_raw),
    .q   (sw_s)
  );

  // ---------------------------------------------------------------------
  // Button debounce FSM
  // ---------------------------------------------------------------------
  btn_state_e      state_q, state_d;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
  logic [HC_W-1:0] hcnt_q, hcnt_d;
  logic            pulse_q, pulse_d;
  logic            long_q, long_d;
  logic            level_q, level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      pulse_q <= 1'b0;
      long_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      pulse_q <= pulse_d;
      long_q  <= long_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    pulse_d = 1'b0;
    long_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;                 // bounce, no pulse
        end else if (dcnt_q == DC_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          dcnt_d  = dcnt_q + DC_W'(1);
        end
      end

      PRESSED: begin
        if (hcnt_q != HC_SAT) hcnt_d = hcnt_q + HC_W'(1);
        if (hcnt_q == HC_LAST) long_d = 1'b1;
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end

      RELEASE_WAIT: begin
        // A bounce back high resumes the same press: hcnt is kept so a
        // long press already reported is not reported again.
        if (btn_s) begin
          state_d = PRESSED;
        end else if (dcnt_q == DC_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d  = dcnt_q + DC_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Level is registered from the next state so it is glitch-free and
    // rises on the same cycle as btn_pulse.
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // ---------------------------------------------------------------------
  // Switch stability filter
  // ---------------------------------------------------------------------
  logic [SW_W-1:0] cand_q;
  logic [SC_W-1:0] scnt_q;
  logic [SW_W-1:0] mode_q;
  logic            chg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      scnt_q <= '0;
      mode_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      chg_q <= 1'b0;

      if (sw_s != cand_q) begin
        cand_q <= sw_s;
        scnt_q <= '0;
      end else if (scnt_q != SC_LAST) begin
        scnt_q <= scnt_q + SC_W'(1);
      end

      // Only a candidate that differs from the current selection raises
      // mode_changed; re-stabilising on the same value is silent.
      if ((scnt_q == SC_LAST) && (cand_q != mode_q)) begin
        mode_q <= cand_q;
        chg_q  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic mode_onehot;
  assign mode_onehot = (mode_q != '0) && ((mode_q & (mode_q - SW_W'(1))) == '0);

  assign pif.btn_pulse    = pulse_q;
  assign pif.btn_level    = level_q;
  assign pif.btn_long     = long_q;
  assign pif.mode_sel     = mode_q;
  assign pif.mode_valid   = mode_onehot || (&mode_q);
  assign pif.mode_changed = chg_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
module tb_panel_input_conditioner;

  localparam int D    = 4;
  localparam int S    = 3;
  localparam int L    = 10;
  localparam int SW_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  panel_input_conditioner_if #(.SW_W(SW_W)) pif ();

  panel_input_conditioner #(
    .DEBOUNCE_CYCLES   (D),
    .SW_STABLE_CYCLES  (S),
    .LONG_PRESS_CYCLES (L),
    .SW_W              (SW_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // event monitor, sampled 1 time unit after each rising edge
  int pulse_cnt, long_cnt, chg_cnt;
  int first_pulse, first_long, first_chg;
  logic level_hi_seen, level_lo_seen;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    pulse_cnt = 0; long_cnt = 0; chg_cnt = 0;
    first_pulse = -1; first_long = -1; first_chg = -1;
    level_hi_seen = 1'b0; level_lo_seen = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pif.btn_pulse) begin
      if (pulse_cnt == 0) first_pulse = cyc;
      pulse_cnt++;
    end
    if (pif.btn_long) begin
      if (long_cnt == 0) first_long = cyc;
      long_cnt++;
    end
    if (pif.mode_changed) begin
      if (chg_cnt == 0) first_chg = cyc;
      chg_cnt++;
    end
    if (pif.btn_level) level_hi_seen = 1'b1;
    else               level_lo_seen = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] outs();
    return 32'({pif.btn_pulse, pif.btn_level, pif.btn_long,
                pif.mode_sel, pif.mode_valid, pif.mode_changed});
  endfunction

  initial begin
    rst = 1'b1;
    pif.btn_raw = 1'b0;
    pif.sw_raw  = '0;
    clr_mon();
    run(3);
    chk("reset_outputs", outs(), 32'h0);

    rst = 1'b0;
    clr_mon();
    tick();
    chk("post_reset_pulse", 32'({pif.btn_pulse, pif.mode_changed}), 32'h0);

    // clean press, held well past the long-press threshold
    clr_mon();
    base = cyc;
    pif.btn_raw = 1'b1;
    run(6);
    chk("press_level_early", 32'(pif.btn_level), 32'h0);
    chk("press_pulse_early", 32'(pulse_cnt), 32'h0);
    run(1);
    chk("press_pulse_edge", 32'({pif.btn_pulse, pif.btn_level}), 32'h3);
    run(29);
    chk("press_pulse_count", 32'(pulse_cnt), 32'h1);
    chk("press_latency", 32'(first_pulse - base), 32'd7);
    chk("long_count", 32'(long_cnt), 32'h1);
    chk("long_latency", 32'(first_long - first_pulse), 32'd10);

    // release glitch while pressed
    clr_mon();
    pif.btn_raw = 1'b0;
    tick(); tick();
    pif.btn_raw = 1'b1;
    run(12);
    chk("glitch_no_pulse", 32'(pulse_cnt), 32'h0);
    chk("glitch_level_held", 32'(level_lo_seen), 32'h0);
    chk("glitch_no_long", 32'(long_cnt), 32'h0);

    // clean release
    pif.btn_raw = 1'b0;
    run(6);
    chk("release_level_hold", 32'(pif.btn_level), 32'h1);
    run(1);
    chk("release_level_drop", 32'(pif.btn_level), 32'h0);
    run(3);

    // bounce on press
    clr_mon();
    pif.btn_raw = 1'b1; tick();
    pif.btn_raw = 1'b0; tick();
    pif.btn_raw = 1'b1; tick();
    pif.btn_raw = 1'b0;
    run(10);
    chk("bounce_no_pulse", 32'(pulse_cnt), 32'h0);
    chk("bounce_no_level", 32'(level_hi_seen), 32'h0);

    // switches 0000 -> 0010
    clr_mon();
    pif.sw_raw = 4'b0010;
    run(5);
    chk("sw1_before", 32'({pif.mode_sel, 4'(chg_cnt)}), 32'h00);
    run(1);
    chk("sw1_update", 32'({pif.mode_sel, pif.mode_changed, pif.mode_valid}), 32'h0B);
    run(1);
    chk("sw1_pulse_end", 32'(pif.mode_changed), 32'h0);

    // 0010 -> 0011 (not a legal code)
    clr_mon();
    pif.sw_raw = 4'b0011;
    run(6);
    chk("sw2_update", 32'({pif.mode_sel, pif.mode_changed, pif.mode_valid}), 32'h0E);
    run(4);
    chk("sw2_one_pulse", 32'(chg_cnt), 32'h1);

    // one-cycle glitch to 1000
    clr_mon();
    pif.sw_raw = 4'b1000; tick();
    pif.sw_raw = 4'b0011;
    run(10);
    chk("sw_glitch_no_chg", 32'(chg_cnt), 32'h0);
    chk("sw_glitch_mode", 32'(pif.mode_sel), 32'h3);

    // 1111 is legal
    pif.sw_raw = 4'b1111;
    run(8);
    chk("sw_all_ones", 32'({pif.mode_sel, pif.mode_valid}), 32'h1F);

    // reset during PRESS_WAIT with dcnt = 2
    pif.btn_raw = 1'b1;
    run(5);
    rst = 1'b1;
    tick();
    chk("midreset_outputs", outs(), 32'h0);
    rst = 1'b0;
    clr_mon();
    base = cyc;
    tick();
    chk("midreset_first_cycle", 32'({pif.btn_pulse, pif.mode_changed}), 32'h0);
    run(11);
    chk("midreset_pulse_count", 32'(pulse_cnt), 32'h1);
    chk("midreset_latency", 32'(first_pulse - base), 32'd7);
    chk("midreset_mode_latency", 32'(first_chg - base), 32'd6);
    chk("midreset_mode", 32'(pif.mode_sel), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
